// File: rtl/f32_to_i16.sv
// IEEE-754 single to signed 16-bit fixed point (round half away from zero, saturating).
// Five-state FSM with a start/busy/done handshake and a fixed four-edge latency.
module f32_to_i16 #(
    parameter int FRAC_BITS = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        din,
    output logic               busy,
    output logic               done,
    output logic signed [15:0] dout,
    output logic               ovf
);

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        SHIFT,
        ROUND,
        OUT
    } state_t;

    localparam logic signed [9:0] FRAC_OFS = 10'(FRAC_BITS);

    state_t state;

    logic [31:0]        din_p0;
    logic               sign_p1;
    logic               zero_p1;
    logic               nan_p1;
    logic               inf_p1;
    logic signed [9:0]  e_p1;
    logic [23:0]        mant_p1;
    logic [16:0]        h_p2;
    logic               big_p2;
    logic [16:0]        mag_p3;

    logic [7:0]         exp_field;
    logic signed [9:0]  e_next;
    logic [4:0]         sh_amt;
    logic [16:0]        h_next;
    logic [16:0]        sat_res;

    // h carries one extra half LSB; adding one then dropping it rounds half away from zero.
    function automatic logic [16:0] round_half(input logic [16:0] h);
        logic [17:0] sum;
        sum = {1'b0, h} + 18'd1;
        round_half = sum[17:1];
    endfunction

    // Returns {ovf, dout}.
    function automatic logic [16:0] saturate(
        input logic        sign,
        input logic        nan,
        input logic        zero,
        input logic        inf,
        input logic        big,
        input logic [16:0] mag
    );
        logic [15:0] neg;
        neg = ~mag[15:0] + 16'd1;
        if (nan) begin
            saturate = {1'b1, 16'h0000};
        end else if (zero) begin
            saturate = {1'b0, 16'h0000};
        end else if (!sign) begin
            if (inf || big || (mag > 17'd32767))
                saturate = {1'b1, 16'h7FFF};
            else
                saturate = {1'b0, mag[15:0]};
        end else begin
            if (inf || big || (mag > 17'd32768))
                saturate = {1'b1, 16'h8000};
            else
                saturate = {1'b0, neg};
        end
    endfunction

    always_comb begin
        exp_field = din_p0[30:23];
        e_next    = signed'({2'b00, exp_field}) - 10'sd127 + FRAC_OFS;
        // 5-bit wraparound maps e in -1..15 onto shifts 23..7.
        sh_amt    = 5'd22 - e_p1[4:0];
        h_next    = 17'(mant_p1 >> sh_amt);
        sat_res   = saturate(sign_p1, nan_p1, zero_p1, inf_p1, big_p2, mag_p3);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            dout    <= '0;
            ovf     <= 1'b0;
            din_p0  <= '0;
            sign_p1 <= 1'b0;
            zero_p1 <= 1'b0;
            nan_p1  <= 1'b0;
            inf_p1  <= 1'b0;
            e_p1    <= '0;
            mant_p1 <= '0;
            h_p2    <= '0;
            big_p2  <= 1'b0;
            mag_p3  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        din_p0 <= din;
                        busy   <= 1'b1;
                        state  <= UNPACK;
                    end
                end
                // p0 -> p1: field split and class flags
                UNPACK: begin
                    sign_p1 <= din_p0[31];
                    e_p1    <= e_next;
                    mant_p1 <= {1'b1, din_p0[22:0]};
                    zero_p1 <= (exp_field == 8'h00);
                    nan_p1  <= (exp_field == 8'hFF) && (din_p0[22:0] != 23'd0);
                    inf_p1  <= (exp_field == 8'hFF) && (din_p0[22:0] == 23'd0);
                    state   <= SHIFT;
                end
                // p1 -> p2: alignment; e=15 is still shifted so -32768 can be told from overflow
                SHIFT: begin
                    if (e_p1 < -10'sd1) begin
                        h_p2   <= '0;
                        big_p2 <= 1'b0;
                    end else if (e_p1 > 10'sd15) begin
                        h_p2   <= '0;
                        big_p2 <= 1'b1;
                    end else begin
                        h_p2   <= h_next;
                        big_p2 <= 1'b0;
                    end
                    state <= ROUND;
                end
                // p2 -> p3: rounding
                ROUND: begin
                    mag_p3 <= round_half(h_p2);
                    state  <= OUT;
                end
                // p3 -> output: sign, saturation, handshake
                OUT: begin
                    {ovf, dout} <= sat_res;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f32_to_i16.sv
// Directed testbench for f32_to_i16: FRAC_BITS=0 and FRAC_BITS=4 instances.
module tb_f32_to_i16;

    logic               clk;
    logic               rst;
    logic               start0, start1;
    logic [31:0]        din0, din1;
    logic               busy0, busy1;
    logic               done0, done1;
    logic signed [15:0] dout0, dout1;
    logic               ovf0, ovf1;

    int checks = 0;
    int errors = 0;

    f32_to_i16 #(.FRAC_BITS(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .din(din0),
        .busy(busy0), .done(done0), .dout(dout0), .ovf(ovf0)
    );

    f32_to_i16 #(.FRAC_BITS(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .din(din1),
        .busy(busy1), .done(done1), .dout(dout1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one conversion and returns the negedge count to done (5 expected) and the outputs.
    task automatic run_conv(input int which, input logic [31:0] v,
                            output int lat, output logic [15:0] d, output logic o);
        @(negedge clk);
        if (which == 0) begin start0 = 1'b1; din0 = v; end
        else begin start1 = 1'b1; din1 = v; end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        lat = 1;
        while (lat < 12 && ((which == 0) ? done0 : done1) !== 1'b1) begin
            @(negedge clk);
            lat++;
        end
        d = (which == 0) ? dout0 : dout1;
        o = (which == 0) ? ovf0 : ovf1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        din0 = '0; din1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy0, done0, dout0, ovf0, busy1, done1, dout1, ovf1} !== 38'd0) begin
            errors++;
            $display("FAIL reset_active: got %h required 0",
                     {busy0, done0, dout0, ovf0, busy1, done1, dout1, ovf1});
        end
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({busy0, done0, dout0, ovf0, busy1, done1, dout1, ovf1} !== 38'd0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %h required 0", i,
                         {busy0, done0, dout0, ovf0, busy1, done1, dout1, ovf1});
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] vin  [7];
        logic [15:0] vexp [7];
        logic        oexp [7];
        int          lat;
        logic [15:0] d;
        logic        o;
        vin  = '{32'h3F800000, 32'hC0200000, 32'h3ECCCCCD, 32'h3F000000,
                 32'h80000000, 32'h00400000, 32'hBFC00000};
        vexp = '{16'h0001, 16'hFFFD, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'hFFFE};
        oexp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            run_conv(0, vin[i], lat, d, o);
            checks++;
            if (lat !== 5) begin
                errors++;
                $display("FAIL basic_latency[%h]: got %0d required 5", vin[i], lat);
            end
            checks++;
            if (d !== vexp[i]) begin
                errors++;
                $display("FAIL basic_dout[%h]: got %h required %h", vin[i], d, vexp[i]);
            end
            checks++;
            if (o !== oexp[i]) begin
                errors++;
                $display("FAIL basic_ovf[%h]: got %b required %b", vin[i], o, oexp[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] vin  [10];
        logic [15:0] vexp [10];
        logic        oexp [10];
        int          lat;
        logic [15:0] d;
        logic        o;
        vin  = '{32'h46FFFE00, 32'h47000000, 32'hC7000000, 32'hC7000100, 32'h7F800000,
                 32'h7FC00000, 32'hFF800000, 32'h501502F9, 32'h46FFFF00, 32'hC6FFFF00};
        vexp = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF,
                 16'h0000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000};
        oexp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            run_conv(0, vin[i], lat, d, o);
            checks++;
            if (d !== vexp[i] || o !== oexp[i] || lat !== 5) begin
                errors++;
                $display("FAIL sat[%h]: got dout=%h ovf=%b lat=%0d required dout=%h ovf=%b lat=5",
                         vin[i], d, o, lat, vexp[i], oexp[i]);
            end
        end
    endtask

    task automatic test_fixed_point();
        logic [31:0] vin  [4];
        logic [15:0] vexp [4];
        logic        oexp [4];
        int          lat;
        logic [15:0] d;
        logic        o;
        vin  = '{32'h3FC00000, 32'hBF000000, 32'h45000000, 32'hC5000000};
        vexp = '{16'h0018, 16'hFFF8, 16'h7FFF, 16'h8000};
        oexp = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_conv(1, vin[i], lat, d, o);
            checks++;
            if (d !== vexp[i] || o !== oexp[i] || lat !== 5) begin
                errors++;
                $display("FAIL fixed4[%h]: got dout=%h ovf=%b lat=%0d required dout=%h ovf=%b lat=5",
                         vin[i], d, o, lat, vexp[i], oexp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [8];
        int          npulse;
        int          pos [2];
        logic [15:0] dsamp [2];
        int          hold_bad;
        vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'hC0E00000, 32'h41200000, 32'h41300000};
        npulse = 0;
        pos = '{0, 0};
        dsamp = '{16'h0, 16'h0};
        hold_bad = 0;
        @(negedge clk);
        start0 = 1'b1;
        din0 = vals[0];
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                if (npulse < 2) begin
                    pos[npulse] = i;
                    dsamp[npulse] = dout0;
                end
                npulse++;
            end
            if (i >= 6 && i <= 9 && dout0 !== 16'h0001) hold_bad++;
            if (i < 8) din0 = vals[i];
            else start0 = 1'b0;
        end
        checks++;
        if (npulse !== 2) begin
            errors++;
            $display("FAIL b2b_pulse_count: got %0d required 2", npulse);
        end
        checks++;
        if (pos[0] !== 5 || pos[1] !== 10) begin
            errors++;
            $display("FAIL b2b_pulse_pos: got %0d,%0d required 5,10", pos[0], pos[1]);
        end
        checks++;
        if (dsamp[0] !== 16'h0001) begin
            errors++;
            $display("FAIL b2b_first_dout: got %h required 0001", dsamp[0]);
        end
        checks++;
        if (dsamp[1] !== 16'hFFF9) begin
            errors++;
            $display("FAIL b2b_second_dout: got %h required fff9", dsamp[1]);
        end
        checks++;
        if (hold_bad !== 0) begin
            errors++;
            $display("FAIL b2b_dout_hold: got %0d bad cycles required 0", hold_bad);
        end
    endtask

    task automatic test_reset_mid();
        int          ndone;
        int          lat;
        logic [15:0] d;
        logic        o;
        ndone = 0;
        @(negedge clk);
        start0 = 1'b1;
        din0 = 32'h3F800000;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({busy0, done0, dout0, ovf0} !== 19'd0) begin
            errors++;
            $display("FAIL midrst_clear: got %h required 0", {busy0, done0, dout0, ovf0});
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) ndone++;
            if (i == 1) rst = 1'b1;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL midrst_no_done: got %0d pulses required 0", ndone);
        end
        run_conv(0, 32'h40400000, lat, d, o);
        checks++;
        if (d !== 16'h0003 || o !== 1'b0 || lat !== 5) begin
            errors++;
            $display("FAIL midrst_next: got dout=%h ovf=%b lat=%0d required dout=0003 ovf=0 lat=5",
                     d, o, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_fixed_point();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
